// File: rtl/ahb_bus_matrix_in_stage.sv
// AHB bus matrix per-master input stage: holds an ungranted address phase and stalls
// the master until the targeted output stage grants this port.
module ahb_bus_matrix_in_stage #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned USER_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSELS,
   input  logic [ADDR_WIDTH-1:0] HADDRS,
   input  logic [USER_WIDTH-1:0] HAUSERS,
   input  logic [1:0]            HTRANSS,
   input  logic                  HWRITES,
   input  logic [2:0]            HSIZES,
   input  logic [2:0]            HBURSTS,
   input  logic [3:0]            HPROTS,
   input  logic [3:0]            HMASTERS,
   input  logic                  HMASTLOCKS,
   input  logic                  HREADYS,
   input  logic                  active_in,
   input  logic                  readyout_in,
   input  logic                  resp_in,
   output logic                  sel_in,
   output logic [ADDR_WIDTH-1:0] addr_in,
   output logic [USER_WIDTH-1:0] auser_in,
   output logic [1:0]            trans_in,
   output logic                  write_in,
   output logic [2:0]            size_in,
   output logic [2:0]            burst_in,
   output logic [3:0]            prot_in,
   output logic [3:0]            master_in,
   output logic                  mastlock_in,
   output logic                  held_tran_in,
   output logic                  HREADYOUTS,
   output logic                  HRESPS
);

   logic                  trans_req;
   logic                  hold_en;
   logic                  pend_tran_q, pend_tran_d;
   logic                  data_phase_q, data_phase_d;

   logic                  hold_sel_q;
   logic [ADDR_WIDTH-1:0] hold_addr_q;
   logic [USER_WIDTH-1:0] hold_auser_q;
   logic [1:0]            hold_trans_q;
   logic                  hold_write_q;
   logic [2:0]            hold_size_q;
   logic [2:0]            hold_burst_q;
   logic [3:0]            hold_prot_q;
   logic [3:0]            hold_master_q;
   logic                  hold_mastlock_q;

   assign trans_req = HSELS & HTRANSS[1] & HREADYS;
   assign hold_en   = HSELS & HREADYS;

   always_comb begin
      pend_tran_d = pend_tran_q;
      // Release takes priority; a new request cannot arrive while stalled anyway.
      if (active_in & readyout_in) begin
         pend_tran_d = 1'b0;
      end else if (trans_req & ~active_in) begin
         pend_tran_d = 1'b1;
      end
   end

   always_comb begin
      data_phase_d = data_phase_q;
      if (readyout_in) begin
         data_phase_d = held_tran_in & active_in;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         pend_tran_q     <= 1'b0;
         data_phase_q    <= 1'b0;
         hold_sel_q      <= 1'b0;
         hold_addr_q     <= '0;
         hold_auser_q    <= '0;
         hold_trans_q    <= '0;
         hold_write_q    <= 1'b0;
         hold_size_q     <= '0;
         hold_burst_q    <= '0;
         hold_prot_q     <= '0;
         hold_master_q   <= '0;
         hold_mastlock_q <= 1'b0;
      end else begin
         pend_tran_q  <= pend_tran_d;
         data_phase_q <= data_phase_d;
         if (hold_en) begin
            hold_sel_q      <= HSELS & HTRANSS[1];
            hold_addr_q     <= HADDRS;
            hold_auser_q    <= HAUSERS;
            hold_trans_q    <= HTRANSS;
            hold_write_q    <= HWRITES;
            hold_size_q     <= HSIZES;
            hold_burst_q    <= HBURSTS;
            hold_prot_q     <= HPROTS;
            hold_master_q   <= HMASTERS;
            hold_mastlock_q <= HMASTLOCKS;
         end
      end
   end

   assign sel_in       = pend_tran_q ? hold_sel_q      : (HSELS & HTRANSS[1]);
   assign addr_in      = pend_tran_q ? hold_addr_q     : HADDRS;
   assign auser_in     = pend_tran_q ? hold_auser_q    : HAUSERS;
   assign trans_in     = pend_tran_q ? hold_trans_q    : HTRANSS;
   assign write_in     = pend_tran_q ? hold_write_q    : HWRITES;
   assign size_in      = pend_tran_q ? hold_size_q     : HSIZES;
   assign burst_in     = pend_tran_q ? hold_burst_q    : HBURSTS;
   assign prot_in      = pend_tran_q ? hold_prot_q     : HPROTS;
   assign master_in    = pend_tran_q ? hold_master_q   : HMASTERS;
   assign mastlock_in  = pend_tran_q ? hold_mastlock_q : HMASTLOCKS;

   assign held_tran_in = trans_req | pend_tran_q;

   assign HREADYOUTS   = pend_tran_q ? 1'b0 : (data_phase_q ? readyout_in : 1'b1);
   assign HRESPS       = data_phase_q & resp_in;

endmodule

// File: tb/tb_ahb_bus_matrix_in_stage.sv
// Bench for ahb_bus_matrix_in_stage: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the master port.
module tb_ahb_bus_matrix_in_stage;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] auser;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [2:0]  burst;
      logic [3:0]  prot;
      logic [3:0]  master;
      logic        lock;
   } ctl_t;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] NONSEQ = 2'b10;

   logic HCLK = 1'b0;
   logic HRESETn;
   logic HSELS;
   ctl_t mst;
   logic HREADYS;
   logic active_in, readyout_in, resp_in;

   logic        sel_in, write_in, mastlock_in, held_tran_in, HREADYOUTS, HRESPS;
   logic [31:0] addr_in, auser_in;
   logic [1:0]  trans_in;
   logic [2:0]  size_in, burst_in;
   logic [3:0]  prot_in, master_in;
   ctl_t        dut_bus;

   int n_chk = 0;
   int n_bad = 0;

   // Model: the master's view of one outstanding, not-yet-granted request plus its data phase.
   logic m_valid = 1'b0;
   logic m_waiting, m_in_data, m_snap_sel;
   ctl_t m_snap;

   always #5 HCLK = ~HCLK;

   ahb_bus_matrix_in_stage #(.ADDR_WIDTH(32), .USER_WIDTH(32)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS),
      .HADDRS(mst.addr), .HAUSERS(mst.auser), .HTRANSS(mst.trans), .HWRITES(mst.write),
      .HSIZES(mst.size), .HBURSTS(mst.burst), .HPROTS(mst.prot), .HMASTERS(mst.master),
      .HMASTLOCKS(mst.lock), .HREADYS(HREADYS),
      .active_in(active_in), .readyout_in(readyout_in), .resp_in(resp_in),
      .sel_in(sel_in), .addr_in(addr_in), .auser_in(auser_in), .trans_in(trans_in),
      .write_in(write_in), .size_in(size_in), .burst_in(burst_in), .prot_in(prot_in),
      .master_in(master_in), .mastlock_in(mastlock_in), .held_tran_in(held_tran_in),
      .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
   );

   assign dut_bus = {addr_in, auser_in, trans_in, write_in, size_in, burst_in,
                     prot_in, master_in, mastlock_in};

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Compare against the model just before the rising edge, then advance the model.
   task automatic step(input string tag);
      logic req, e_sel, e_req, e_rdy, e_resp;
      ctl_t e_bus;
      #1;
      req    = HSELS & mst.trans[1] & HREADYS;
      e_bus  = m_waiting ? m_snap : mst;
      e_sel  = m_waiting ? m_snap_sel : (HSELS & mst.trans[1]);
      e_req  = req | m_waiting;
      e_rdy  = m_waiting ? 1'b0 : (m_in_data ? readyout_in : 1'b1);
      e_resp = m_in_data ? resp_in : 1'b0;
      if (m_valid) begin
         check({tag, ".bus"},  128'(dut_bus),      128'(e_bus));
         check({tag, ".sel"},  128'(sel_in),       128'(e_sel));
         check({tag, ".req"},  128'(held_tran_in), 128'(e_req));
         check({tag, ".rdy"},  128'(HREADYOUTS),   128'(e_rdy));
         check({tag, ".resp"}, 128'(HRESPS),       128'(e_resp));
      end
      if (!HRESETn) begin
         m_valid = 1'b1; m_waiting = 1'b0; m_in_data = 1'b0; m_snap = '0; m_snap_sel = 1'b0;
      end else begin
         if (HSELS & HREADYS) begin
            m_snap     = mst;
            m_snap_sel = HSELS & mst.trans[1];
         end
         if (active_in & readyout_in)  m_waiting = 1'b0;
         else if (req & !active_in)    m_waiting = 1'b1;
         if (readyout_in)              m_in_data = e_req & active_in;
      end
      @(negedge HCLK);
   endtask

   task automatic drive(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                        input logic hr, input logic act, input logic rdy, input logic rsp);
      HSELS = sel; mst = '0; mst.trans = tr; mst.addr = a; mst.auser = ~a;
      mst.size = 3'd2; mst.prot = 4'h3; mst.master = 4'h5;
      HREADYS = hr; active_in = act; readyout_in = rdy; resp_in = rsp;
   endtask

   initial begin
      HRESETn = 1'b0;
      drive(1'b1, NONSEQ, 32'h0000_1000, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge HCLK);
      step("rst0");
      step("rst1");
      HRESETn = 1'b1;
      #1;
      check("rst_req_live", 128'(held_tran_in), 128'(1'b1));
      check("rst_rdy",      128'(HREADYOUTS),   128'(1'b1));
      check("rst_resp",     128'(HRESPS),       128'(1'b0));
      step("rst2");
      drive(1'b1, NONSEQ, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b0);
      step("rst3");

      // Granted single write
      drive(1'b1, NONSEQ, 32'h2000_0010, 1'b1, 1'b1, 1'b1, 1'b0);
      mst.write = 1'b1;
      #1;
      check("wr_addr", 128'(addr_in), 128'(32'h2000_0010));
      step("wr0");
      drive(1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      check("wr_dp_wait", 128'(HREADYOUTS), 128'(1'b0));
      step("wr1");
      drive(1'b1, IDLE, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      check("wr_dp_done", 128'(HREADYOUTS), 128'(1'b1));
      step("wr2");

      // Held transfer
      drive(1'b1, NONSEQ, 32'h4000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      step("hold0");
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, NONSEQ, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0);
         #1;
         check("hold_addr", 128'(addr_in),      128'(32'h4000_0000));
         check("hold_rdy",  128'(HREADYOUTS),   128'(1'b0));
         check("hold_req",  128'(held_tran_in), 128'(1'b1));
         step("hold1");
      end
      drive(1'b1, NONSEQ, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      check("grant_addr", 128'(addr_in), 128'(32'h4000_0000));
      step("hold2");
      drive(1'b1, IDLE, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      check("rel_rdy", 128'(HREADYOUTS), 128'(1'b1));
      step("hold3");

      // Slave wait then two-cycle ERROR
      drive(1'b1, NONSEQ, 32'h5000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
      step("err0");
      drive(1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      check("err_rdy0", 128'(HREADYOUTS), 128'(1'b0));
      check("err_rsp0", 128'(HRESPS),     128'(1'b0));
      step("err1");
      drive(1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      #1;
      check("err_rdy1", 128'(HREADYOUTS), 128'(1'b0));
      check("err_rsp1", 128'(HRESPS),     128'(1'b1));
      step("err2");
      drive(1'b1, IDLE, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      #1;
      check("err_rdy2", 128'(HREADYOUTS), 128'(1'b1));
      check("err_rsp2", 128'(HRESPS),     128'(1'b1));
      step("err3");

      // IDLE / BUSY raise no request
      drive(1'b1, IDLE, 32'h7000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      check("idle_req", 128'(held_tran_in), 128'(1'b0));
      step("idle");
      drive(1'b1, BUSY, 32'h7000_0004, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      check("busy_req", 128'(held_tran_in), 128'(1'b0));
      step("busy");
      drive(1'b1, IDLE, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      check("busy_rdy", 128'(HREADYOUTS), 128'(1'b1));
      step("busy2");

      // Reset while a transfer is waiting
      drive(1'b1, NONSEQ, 32'h6000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      step("mrst0");
      drive(1'b1, NONSEQ, 32'h6000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
      HRESETn = 1'b0;
      step("mrst1");
      HRESETn = 1'b1;
      drive(1'b1, IDLE, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      check("mrst_req", 128'(held_tran_in), 128'(1'b0));
      check("mrst_rdy", 128'(HREADYOUTS),   128'(1'b1));
      step("mrst2");

      // Random traffic; HREADYS loops back from the model's expected HREADYOUTS
      for (int i = 0; i < 600; i++) begin
         HRESETn     = ($urandom_range(0, 49) != 0);
         HSELS       = ($urandom_range(0, 3) != 0);
         mst.addr    = $urandom;
         mst.auser   = $urandom;
         mst.trans   = 2'($urandom_range(0, 3));
         mst.write   = 1'($urandom);
         mst.size    = 3'($urandom);
         mst.burst   = 3'($urandom);
         mst.prot    = 4'($urandom);
         mst.master  = 4'($urandom);
         mst.lock    = 1'($urandom);
         active_in   = 1'($urandom);
         readyout_in = ($urandom_range(0, 3) != 0);
         resp_in     = ($urandom_range(0, 3) == 0);
         HREADYS     = m_waiting ? 1'b0 : (m_in_data ? readyout_in : 1'b1);
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
